mmio_uart_tx: RTL and testbench

Memory-mapped console transmitter that consumes core data-bus stores to the I/O region (addr[ADDR_WIDTH-1:ADDR_WIDTH-2] == 2'b01). It replaces the simulation-only character print with synthesizable hardware. Accepted bytes are buffered in a FIFO and serialized on an 8N1 UART line. It sits beside the RAM on the core's data port; top-level decode steers I/O-region requests here and routes data_gnt/data_rvalid/data_rdata back from this block.

---
 rtl/mmio_uart_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter: bus stores to TXDATA are queued in a
// FIFO and shifted out LSB first at a programmable number of cycles per bit.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for div_lat cycles
// DATA  | eight data bits, LSB first, div_lat cycles each
// STOP  | stop bit (high); chains directly into START if more bytes wait
module mmio_uart_tx #(
   parameter int                   ADDR_WIDTH  = 22,
   parameter int                   FIFO_DEPTH  = 16,
   parameter int                   DIV_WIDTH   = 16,
   parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd434
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  data_req_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [31:0]           data_wdata_i,
   output logic [31:0]           data_rdata_o,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic                  tx_o,
   output logic                  irq_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   logic [1:0]           reg_sel;
   logic                 wr_acc;
   logic                 rd_acc;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic                 busy;

   logic [7:0]           fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q;
   logic [PW-1:0]        rd_ptr_q;
   logic [CW-1:0]        count_q;
   logic [CW-1:0]        count_nxt;

   logic [DIV_WIDTH-1:0] div_q;
   logic                 irq_en_q;
   logic                 irq_en_nxt;
   logic [31:0]          rdata_nxt;
   logic [7:0]           count_ext;

   state_t               state_q, state_d;
   logic [7:0]           shift_q, shift_d;
   logic [2:0]           bit_q, bit_d;
   logic [DIV_WIDTH-1:0] baud_q, baud_d;
   logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
   logic                 tx_q, tx_d;
   logic                 start_frame;
   logic                 baud_done;

   logic                 unused_ok;
   assign unused_ok = ^{data_addr_i, data_be_i, data_wdata_i};

   assign reg_sel = data_addr_i[3:2];
   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign busy    = (state_q != S_IDLE);

   // full is a registered flag, so a pop in the same cycle does not release a stalled store
   assign data_gnt_o = rstn_i && data_req_i && !(data_we_i && (reg_sel == 2'd0) && full);
   assign wr_acc     = data_gnt_o && data_we_i;
   assign rd_acc     = data_gnt_o && !data_we_i;
   assign push       = wr_acc && (reg_sel == 2'd0) && data_be_i[0];

   always_comb begin
      count_nxt = count_q;
      case ({push, pop})
         2'b10:   count_nxt = count_q + CW'(1);
         2'b01:   count_nxt = count_q - CW'(1);
         default: count_nxt = count_q;
      endcase
   end

   always_comb begin
      irq_en_nxt = irq_en_q;
      if (wr_acc && (reg_sel == 2'd3)) begin
         irq_en_nxt = data_wdata_i[0];
      end
   end

   assign count_ext = 8'(count_q);

   always_comb begin
      rdata_nxt = 32'd0;
      case (reg_sel)
         2'd1:    rdata_nxt = {16'd0, count_ext, 5'd0, busy, empty, full};
         2'd2:    rdata_nxt = 32'(div_q);
         2'd3:    rdata_nxt = {31'd0, irq_en_q};
         default: rdata_nxt = 32'd0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= data_wdata_i[7:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         div_q         <= DEFAULT_DIV;
         irq_en_q      <= 1'b0;
         irq_o         <= 1'b0;
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= 32'd0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_nxt;
         if (wr_acc && (reg_sel == 2'd2)) begin
            div_q <= (data_wdata_i[DIV_WIDTH-1:0] == '0) ? DIV_WIDTH'(1)
                                                         : data_wdata_i[DIV_WIDTH-1:0];
         end
         irq_en_q      <= irq_en_nxt;
         // built from next-state values so the level tracks the FIFO without lag
         irq_o         <= irq_en_nxt && (count_nxt == '0);
         data_rvalid_o <= data_gnt_o;
         data_rdata_o  <= rd_acc ? rdata_nxt : 32'd0;
      end
   end

   assign baud_done = (baud_q == '0);

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_d       = bit_q;
      baud_d      = baud_q;
      div_lat_d   = div_lat_q;
      tx_d        = tx_q;
      pop         = 1'b0;
      start_frame = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d        = 1'b1;
            start_frame = !empty;
         end
         S_START: begin
            if (baud_done) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               bit_d   = 3'd0;
               baud_d  = div_lat_q - DIV_WIDTH'(1);
            end else begin
               baud_d = baud_q - DIV_WIDTH'(1);
            end
         end
         S_DATA: begin
            if (baud_done) begin
               baud_d = div_lat_q - DIV_WIDTH'(1);
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q - DIV_WIDTH'(1);
            end
         end
         S_STOP: begin
            if (baud_done) begin
               if (!empty) begin
                  start_frame = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q - DIV_WIDTH'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
      // divisor is sampled once per frame so mid-frame writes take effect next frame
      if (start_frame) begin
         pop       = 1'b1;
         shift_d   = fifo_mem[rd_ptr_q];
         div_lat_d = div_q;
         baud_d    = div_q - DIV_WIDTH'(1);
         tx_d      = 1'b0;
         state_d   = S_START;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q   <= S_IDLE;
         shift_q   <= 8'd0;
         bit_q     <= 3'd0;
         baud_q    <= '0;
         div_lat_q <= DEFAULT_DIV;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_q     <= bit_d;
         baud_q    <= baud_d;
         div_lat_q <= div_lat_d;
         tx_q      <= tx_d;
      end
   end

   assign tx_o = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: bus responses and serial frames are
// queued at issue time and checked by independent monitors.
module tb_mmio_uart_tx;

   localparam int AW = 22;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic          data_req_i;
   logic [AW-1:0] data_addr_i;
   logic          data_we_i;
   logic [3:0]    data_be_i;
   logic [31:0]   data_wdata_i;
   logic [31:0]   data_rdata_o;
   logic          data_gnt_o;
   logic          data_rvalid_o;
   logic          tx_o;
   logic          irq_o;

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   int            mon_div = 434;
   logic          gnt_d = 1'b0;
   logic [31:0]   rd_q[$];
   logic [7:0]    tx_q[$];
   int            frame_starts[$];

   mmio_uart_tx dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .data_req_i   (data_req_i),
      .data_addr_i  (data_addr_i),
      .data_we_i    (data_we_i),
      .data_be_i    (data_be_i),
      .data_wdata_i (data_wdata_i),
      .data_rdata_o (data_rdata_o),
      .data_gnt_o   (data_gnt_o),
      .data_rvalid_o(data_rvalid_o),
      .tx_o         (tx_o),
      .irq_o        (irq_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      cyc   <= cyc + 1;
      gnt_d <= data_gnt_o;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // response monitor
   always @(negedge clk_i) begin
      if (data_rvalid_o || gnt_d) chk("rvalid_timing", {31'd0, data_rvalid_o}, {31'd0, gnt_d});
      if (data_rvalid_o) begin
         if (rd_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rvalid_unexpected actual=rvalid required=no_response cycle=%0d", cyc);
         end else begin
            chk("rdata", data_rdata_o, rd_q.pop_front());
         end
      end else if (data_rdata_o != 32'd0) begin
         n_checks++;
         n_errors++;
         $display("FAIL rdata_idle actual=0x%0h required=0x0 cycle=%0d", data_rdata_o, cyc);
      end
   end

   // serial-line monitor: checks every cycle of each frame against the queued byte
   initial begin : tx_mon
      logic [9:0] fr;
      logic [7:0] b;
      logic       aborted;
      int         d;
      int         bad;
      forever begin
         @(negedge clk_i);
         if (rstn_i === 1'b1 && tx_o === 1'b0) begin
            frame_starts.push_back(cyc);
            d       = mon_div;
            bad     = 0;
            aborted = 1'b0;
            if (tx_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL frame_unexpected actual=start_bit required=idle cycle=%0d", cyc);
               b = 8'h00;
            end else begin
               b = tx_q.pop_front();
            end
            fr = {1'b1, b, 1'b0};
            for (int s = 0; s < 10 && !aborted; s++) begin
               for (int k = 0; k < d && !aborted; k++) begin
                  if (s != 0 || k != 0) @(negedge clk_i);
                  if (!rstn_i) aborted = 1'b1;
                  else if (tx_o !== fr[s]) bad++;
               end
            end
            if (!aborted) chk($sformatf("frame_%02h_bad_cycles", b), bad, 0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic bus(input logic w, input logic [3:0] off, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input int budget,
                      output logic granted, output int waited);
      @(negedge clk_i);
      data_req_i   = 1'b1;
      data_we_i    = w;
      data_addr_i  = {2'b01, {(AW-6){1'b0}}, off};
      data_be_i    = be;
      data_wdata_i = wd;
      #1;
      waited = 0;
      while (!data_gnt_o && waited < budget) begin
         @(negedge clk_i);
         #1;
         waited++;
      end
      granted = data_gnt_o;
      if (granted) begin
         rd_q.push_back(exp_rd);
      end else begin
         n_checks++;
         n_errors++;
         $display("FAIL gnt_timeout actual=no_grant required=grant off=0x%0h", off);
      end
      @(posedge clk_i);
      #1;
      data_req_i = 1'b0;
      data_we_i  = 1'b0;
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] wd);
      logic g;
      int   n;
      bus(1'b1, off, 4'hF, wd, 32'd0, 50, g, n);
   endtask

   task automatic rd(input logic [3:0] off, input logic [31:0] exp);
      logic g;
      int   n;
      bus(1'b0, off, 4'hF, 32'd0, exp, 50, g, n);
   endtask

   task automatic push_byte(input logic [7:0] b);
      tx_q.push_back(b);
      wr(4'h0, {24'd0, b});
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   initial begin
      logic g;
      int   n;
      int   base;

      rstn_i       = 1'b0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_addr_i  = '0;
      data_be_i    = 4'h0;
      data_wdata_i = 32'd0;
      wait_cycles(3);
      data_req_i  = 1'b1;
      data_addr_i = {2'b01, {(AW-6){1'b0}}, 4'h4};
      #1;
      chk("rst_gnt", {31'd0, data_gnt_o}, 32'd0);
      chk("rst_tx", {31'd0, tx_o}, 32'd1);
      chk("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
      chk("rst_irq", {31'd0, irq_o}, 32'd0);
      wait_cycles(1);
      data_req_i = 1'b0;
      rstn_i     = 1'b1;
      rd(4'h4, 32'h0000_0002);
      rd(4'h8, 32'd434);
      rd(4'hC, 32'd0);

      // single byte, 4 cycles per bit
      wr(4'h8, 32'd4);
      mon_div = 4;
      base = frame_starts.size();
      push_byte(8'h41);
      wait_cycles(50);
      chk("t1_frames", frame_starts.size() - base, 1);
      rd(4'h4, 32'h0000_0002);
      rd(4'h8, 32'd4);

      // byte enables and register quirks
      bus(1'b1, 4'h0, 4'b1110, 32'h77, 32'd0, 50, g, n);
      wait_cycles(5);
      rd(4'h4, 32'h0000_0002);
      wr(4'h8, 32'd0);
      rd(4'h8, 32'd1);
      rd(4'hC, 32'd0);
      wr(4'h4, 32'hFFFF_FFFF);
      rd(4'h4, 32'h0000_0002);
      rd(4'h0, 32'd0);

      // back-to-back frames, 2 cycles per bit
      wr(4'h8, 32'd2);
      mon_div = 2;
      base = frame_starts.size();
      push_byte(8'h55);
      push_byte(8'hAA);
      push_byte(8'h0F);
      wait_cycles(70);
      chk("t3_frames", frame_starts.size() - base, 3);
      chk("t3_gap01", frame_starts[base+1] - frame_starts[base], 20);
      chk("t3_gap12", frame_starts[base+2] - frame_starts[base+1], 20);
      rd(4'h4, 32'h0000_0002);

      // interrupt
      wr(4'hC, 32'd1);
      wait_cycles(1);
      chk("irq_empty", {31'd0, irq_o}, 32'd1);
      rd(4'hC, 32'd1);
      tx_q.push_back(8'hC3);
      wr(4'h0, 32'hC3);
      chk("irq_count1", {31'd0, irq_o}, 32'd0);
      @(posedge clk_i);
      #1;
      chk("irq_after_pop", {31'd0, irq_o}, 32'd1);
      wait_cycles(25);
      chk("irq_idle", {31'd0, irq_o}, 32'd1);
      wr(4'hC, 32'd0);
      chk("irq_disabled", {31'd0, irq_o}, 32'd0);

      // backpressure: 17 bytes fill a 16-deep FIFO behind the active frame
      wr(4'h8, 32'd100);
      mon_div = 100;
      base = frame_starts.size();
      for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i));
      rd(4'h4, 32'h0000_1005);
      tx_q.push_back(8'h99);
      bus(1'b1, 4'h0, 4'hF, 32'h99, 32'd0, 3000, g, n);
      chk("bp_granted", {31'd0, g}, 32'd1);
      chk("bp_frames_at_grant", frame_starts.size() - base, 2);
      chk("bp_stalled", {31'd0, (n > 900)}, 32'd1);
      rd(4'h4, 32'h0000_1005);
      @(negedge clk_i);
      rstn_i = 1'b0;
      tx_q.delete();
      wait_cycles(2);
      rstn_i  = 1'b1;
      mon_div = 434;

      // reset during the data phase with bytes queued
      wr(4'h8, 32'd4);
      mon_div = 4;
      for (int i = 0; i < 5; i++) push_byte(8'hA1 + 8'(i));
      wait_cycles(8);
      @(negedge clk_i);
      rstn_i      = 1'b0;
      data_req_i  = 1'b1;
      data_we_i   = 1'b0;
      data_addr_i = {2'b01, {(AW-6){1'b0}}, 4'h4};
      tx_q.delete();
      #1;
      chk("mid_rst_gnt", {31'd0, data_gnt_o}, 32'd0);
      @(posedge clk_i);
      #1;
      chk("mid_rst_tx", {31'd0, tx_o}, 32'd1);
      chk("mid_rst_irq", {31'd0, irq_o}, 32'd0);
      @(negedge clk_i);
      chk("mid_rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
      data_req_i = 1'b0;
      @(negedge clk_i);
      rstn_i  = 1'b1;
      mon_div = 434;
      rd(4'h4, 32'h0000_0002);
      rd(4'h8, 32'd434);
      rd(4'hC, 32'd0);
      wait_cycles(20);

      chk("rd_q_drained", rd_q.size(), 0);
      chk("tx_q_drained", tx_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
